// File: rtl/cmd_fetch.sv
// Command-stream fetcher: walks a word stream from memory, decodes commands and
// hands out LOAD_MATRIX payloads as four 128-bit rows over valid/ready handshakes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start after reset
// S_FETCH   | sample command word at addr1 = pc, decode and check it
// S_CMD_OUT | present decoded command until cmd_ready
// S_ROW_FETCH | sample four payload words at addr2 = pc
// S_ROW_OUT | present payload row until row_ready
// S_DONE    | stream finished cleanly (done = 1) until next start
// S_ERR     | bad command or short payload (err = 1) until next start
module cmd_fetch (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [31:0]  base_addr,
   input  logic [15:0]  len_words,
   output logic [31:0]  addr1,
   output logic [31:0]  addr2,
   input  logic [31:0]  read0,
   input  logic [31:0]  read1,
   input  logic [31:0]  read2,
   input  logic [31:0]  read3,
   input  logic [31:0]  read4,
   output logic         cmd_valid,
   input  logic         cmd_ready,
   output logic [7:0]   cmd_op,
   output logic [3:0]   cmd_arg,
   output logic         row_valid,
   input  logic         row_ready,
   output logic [127:0] row_data,
   output logic [1:0]   row_idx,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam logic [7:0] OP_HALT        = 8'h00;
   localparam logic [7:0] OP_MATRIX_MODE = 8'h10;
   localparam logic [7:0] OP_LOAD_MATRIX = 8'h13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CMD_OUT,
      S_ROW_FETCH,
      S_ROW_OUT,
      S_DONE,
      S_ERR
   } state_t;

   state_t         state_q, state_d;
   logic [31:0]    pc_q, pc_d;
   logic [31:0]    end_q, end_d;
   logic [7:0]     op_q, op_d;
   logic [3:0]     arg_q, arg_d;
   logic [1:0]     row_idx_q, row_idx_d;
   logic [127:0]   row_data_q, row_data_d;

   logic [31:0]    start_pc;
   logic [31:0]    start_end;
   logic [31:0]    pc_plus4;
   logic [31:0]    pc_plus16;
   logic           load_fits;
   logic           word_pay;
   logic [7:0]     word_op;
   logic           unused_bits;

   assign start_pc    = {base_addr[31:2], 2'b00};
   assign start_end   = start_pc + {14'd0, len_words, 2'b00};
   assign pc_plus4    = pc_q + 32'd4;
   assign pc_plus16   = pc_q + 32'd16;
   // 33-bit compare so a payload that would wrap past 2^32 is still caught
   assign load_fits   = ({1'b0, pc_q} + 33'd64) <= {1'b0, end_q};
   assign word_op     = read0[7:0];
   assign word_pay    = read0[31];
   assign unused_bits = ^{base_addr[1:0], read0[30:12]};

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      end_d      = end_q;
      op_d       = op_q;
      arg_d      = arg_q;
      row_idx_d  = row_idx_q;
      row_data_d = row_data_q;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               pc_d      = start_pc;
               end_d     = start_end;
               row_idx_d = 2'd0;
               state_d   = (len_words == 16'd0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            op_d  = word_op;
            arg_d = read0[11:8];
            pc_d  = pc_plus4;
            case (word_op)
               OP_HALT:        state_d = word_pay ? S_ERR : S_DONE;
               OP_MATRIX_MODE: state_d = word_pay ? S_ERR : S_CMD_OUT;
               OP_LOAD_MATRIX: state_d = word_pay ? S_CMD_OUT : S_ERR;
               default:        state_d = S_ERR;
            endcase
         end
         S_CMD_OUT: begin
            if (cmd_ready) begin
               if (op_q == OP_LOAD_MATRIX) begin
                  row_idx_d = 2'd0;
                  state_d   = load_fits ? S_ROW_FETCH : S_ERR;
               end else begin
                  state_d = (pc_q == end_q) ? S_DONE : S_FETCH;
               end
            end
         end
         S_ROW_FETCH: begin
            row_data_d = {read1, read2, read3, read4};
            state_d    = S_ROW_OUT;
         end
         S_ROW_OUT: begin
            if (row_ready) begin
               pc_d      = pc_plus16;
               row_idx_d = row_idx_q + 2'd1;
               if (row_idx_q == 2'd3) begin
                  state_d = (pc_plus16 == end_q) ? S_DONE : S_FETCH;
               end else begin
                  state_d = S_ROW_FETCH;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         end_q      <= '0;
         op_q       <= '0;
         arg_q      <= '0;
         row_idx_q  <= '0;
         row_data_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         end_q      <= end_d;
         op_q       <= op_d;
         arg_q      <= arg_d;
         row_idx_q  <= row_idx_d;
         row_data_q <= row_data_d;
      end
   end

   assign addr1     = pc_q;
   assign addr2     = pc_q;
   assign cmd_valid = (state_q == S_CMD_OUT);
   assign cmd_op    = op_q;
   assign cmd_arg   = arg_q;
   assign row_valid = (state_q == S_ROW_OUT);
   assign row_data  = row_data_q;
   assign row_idx   = row_idx_q;
   assign busy      = (state_q == S_FETCH) || (state_q == S_CMD_OUT) ||
                      (state_q == S_ROW_FETCH) || (state_q == S_ROW_OUT);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);

endmodule

// File: tb/tb_cmd_fetch.sv
// Bench for cmd_fetch: directed streams plus randomized streams, checked against
// a stream-walking reference model over a bench-owned word memory.
module tb_cmd_fetch;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [31:0]  base_addr;
   logic [15:0]  len_words;
   logic [31:0]  addr1, addr2;
   logic [31:0]  read0, read1, read2, read3, read4;
   logic         cmd_valid, cmd_ready;
   logic [7:0]   cmd_op;
   logic [3:0]   cmd_arg;
   logic         row_valid, row_ready;
   logic [127:0] row_data;
   logic [1:0]   row_idx;
   logic         busy, done, err;

   always #5 clk = ~clk;

   cmd_fetch dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len_words(len_words),
      .addr1(addr1), .addr2(addr2), .read0(read0), .read1(read1), .read2(read2),
      .read3(read3), .read4(read4), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .row_valid(row_valid), .row_ready(row_ready),
      .row_data(row_data), .row_idx(row_idx), .busy(busy), .done(done), .err(err)
   );

   logic [31:0] mem [0:511];
   logic [31:0] a2_4, a2_8, a2_12;
   assign a2_4  = addr2 + 32'd4;
   assign a2_8  = addr2 + 32'd8;
   assign a2_12 = addr2 + 32'd12;
   assign read0 = mem[addr1[10:2]];
   assign read1 = mem[addr2[10:2]];
   assign read2 = mem[a2_4[10:2]];
   assign read3 = mem[a2_8[10:2]];
   assign read4 = mem[a2_12[10:2]];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mrd(input logic [31:0] a);
      return mem[a[10:2]];
   endfunction

   // reference model: expected commands, rows (with their addresses) and final status
   logic [11:0]  exp_cmd[$];
   logic [129:0] exp_row[$];
   logic [31:0]  exp_row_addr[$];
   int           exp_end;

   task automatic model(input logic [31:0] base, input logic [15:0] len);
      logic [31:0] pc, endp, w;
      int guard;
      exp_cmd.delete();
      exp_row.delete();
      exp_row_addr.delete();
      pc   = base & 32'hFFFF_FFFC;
      endp = pc + 32'(len) * 32'd4;
      exp_end = (len == 16'd0) ? 1 : 0;
      guard = 0;
      while (exp_end == 0 && guard < 2000) begin
         guard++;
         w  = mrd(pc);
         pc = pc + 32'd4;
         if (w[7:0] == 8'h00 && !w[31]) exp_end = 1;
         else if (w[7:0] == 8'h10 && !w[31]) begin
            exp_cmd.push_back({w[11:8], w[7:0]});
            if (pc == endp) exp_end = 1;
         end else if (w[7:0] == 8'h13 && w[31]) begin
            exp_cmd.push_back({w[11:8], w[7:0]});
            if (({1'b0, pc} + 33'd64) > {1'b0, endp}) exp_end = 2;
            else begin
               for (int r = 0; r < 4; r++) begin
                  exp_row.push_back({2'(r), mrd(pc), mrd(pc + 32'd4), mrd(pc + 32'd8), mrd(pc + 32'd12)});
                  exp_row_addr.push_back(pc);
                  pc = pc + 32'd16;
               end
               if (pc == endp) exp_end = 1;
            end
         end else exp_end = 2;
      end
   endtask

   int           hs_cyc[$];
   int           first_valid_cyc, end_cyc, row_vcyc, row_hs, cmd_hs;
   logic [127:0] first_row;

   // mode 0: readies high; 1: random readies + ignored start pulses; 2: stall row 1 for 5 cycles
   task automatic run_stream(input logic [31:0] base, input logic [15:0] len, input int mode);
      int   cyc, stall;
      logic fin;
      model(base, len);
      hs_cyc.delete();
      first_valid_cyc = -1; end_cyc = -1; row_vcyc = 0; row_hs = 0; cmd_hs = 0;
      first_row = '0;
      @(negedge clk);
      base_addr = base; len_words = len; start = 1'b1; cmd_ready = 1'b0; row_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; base_addr = $urandom;
      cyc = 1; stall = 0; fin = 1'b0;
      while (!fin && cyc < 3000) begin
         if (done || err) begin
            fin = 1'b1;
            end_cyc = cyc;
         end else begin
            check("busy_active", 130'(busy), 130'(1));
            if (mode == 0) begin
               cmd_ready = 1'b1; row_ready = 1'b1;
            end else if (mode == 1) begin
               cmd_ready = ($urandom_range(0, 2) != 0);
               row_ready = ($urandom_range(0, 2) != 0);
               if ($urandom_range(0, 9) == 0) begin
                  start = 1'b1; base_addr = $urandom; len_words = 16'($urandom);
               end
            end else begin
               cmd_ready = 1'b1;
               if (row_valid && row_idx == 2'd1 && stall < 5) begin
                  row_ready = 1'b0; stall++;
               end else row_ready = 1'b1;
            end
            if (cmd_valid) begin
               if (first_valid_cyc < 0) first_valid_cyc = cyc;
               if (exp_cmd.size() == 0) check("cmd_extra", 130'(1), 130'(0));
               else check("cmd_value", 130'({cmd_arg, cmd_op}), 130'(exp_cmd[0]));
               if (cmd_ready) begin
                  if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
                  hs_cyc.push_back(cyc);
                  cmd_hs++;
               end
            end
            if (row_valid) begin
               row_vcyc++;
               if (exp_row.size() == 0) check("row_extra", 130'(1), 130'(0));
               else begin
                  check("row_value", {row_idx, row_data}, exp_row[0]);
                  check("row_addr", 130'(addr2), 130'(exp_row_addr[0]));
               end
               if (row_ready) begin
                  if (row_hs == 0) first_row = row_data;
                  row_hs++;
                  if (exp_row.size() != 0) begin
                     void'(exp_row.pop_front());
                     void'(exp_row_addr.pop_front());
                  end
               end
            end
         end
         @(negedge clk);
         start = 1'b0;
         if (!fin) cyc++;
      end
      check("timeout", 130'(fin), 130'(1));
      check("end_status", 130'({done, err}), 130'((exp_end == 1) ? 2'b10 : 2'b01));
      check("busy_end", 130'(busy), 130'(0));
      check("cmds_left", 130'(exp_cmd.size()), 130'(0));
      check("rows_left", 130'(exp_row.size()), 130'(0));
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_flags"}, 130'({cmd_valid, row_valid, busy, done, err}), 130'(0));
      check({tag, "_cmd"}, 130'({cmd_op, cmd_arg}), 130'(0));
      check({tag, "_row"}, {row_idx, row_data}, 130'(0));
      check({tag, "_addr"}, 130'({addr1, addr2}), 130'(0));
   endtask

   task automatic load_matrix_stream(input int wi);
      mem[wi]     = 32'h8000_1013 & 32'hFFFF_F0FF;
      mem[wi + 1] = 32'h4201_3333;
      mem[wi + 2] = 32'h42C8_A666;
      mem[wi + 3] = 32'h44A7_2000;
      mem[wi + 4] = 32'h3F80_0000;
      for (int i = 5; i <= 16; i++) mem[wi + i] = $urandom;
   endtask

   initial begin
      int b, l, i, r;
      logic found;
      for (int k = 0; k < 512; k++) mem[k] = $urandom;
      rst = 1'b1; start = 1'b1; base_addr = 32'h40; len_words = 16'd5;
      cmd_ready = 1'b0; row_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0; start = 1'b0;

      // two MATRIX_MODE commands from address 0
      mem[0] = 32'h0000_0010;
      mem[1] = 32'h0000_0110;
      run_stream(32'h0, 16'd2, 0);
      check("lat_first_valid", 130'(first_valid_cyc), 130'(2));
      check("cmd_count_027", 130'(cmd_hs), 130'(2));
      if (hs_cyc.size() == 2) begin
         check("hs_spacing", 130'(hs_cyc[1] - hs_cyc[0]), 130'(2));
         check("done_after_hs", 130'(end_cyc - hs_cyc[1]), 130'(1));
      end

      // zero-length stream finishes immediately
      run_stream(32'h80, 16'd0, 0);
      check("len0_latency", 130'(end_cyc), 130'(1));

      // LOAD_MATRIX with full payload (opcode word 0x80001013 carries arg 0)
      load_matrix_stream(16);
      mem[16] = 32'h8000_1013;
      check("load_arg_sanity", 130'(mem[16][11:8]), 130'(0));
      run_stream(32'h40, 16'd17, 0);
      check("rows_028", 130'(row_hs), 130'(4));
      check("row0_028", 130'(first_row), 130'(128'h42013333_42C8A666_44A72000_3F800000));

      // same stream with short length: error after the handshake, no rows
      run_stream(32'h40, 16'd10, 0);
      check("cmds_029", 130'(cmd_hs), 130'(1));
      check("no_row_valid_029", 130'(row_vcyc), 130'(0));

      // row 1 stalled for five cycles
      run_stream(32'h40, 16'd17, 2);
      check("rows_030", 130'(row_hs), 130'(4));
      check("stall_cycles_030", 130'(row_vcyc), 130'(9));

      // HALT in the middle of the stream, then an undefined opcode
      mem[128] = 32'h0000_0310; mem[129] = 32'h0000_0000; mem[130] = 32'h0000_0410;
      run_stream(32'h200, 16'd3, 0);
      check("cmds_halt", 130'(cmd_hs), 130'(1));
      mem[192] = 32'h0000_0055;
      run_stream(32'h300, 16'd2, 0);
      check("cmds_bad_op", 130'(cmd_hs), 130'(0));

      // reset during row 2, with start held alongside reset
      @(negedge clk);
      base_addr = 32'h40; len_words = 16'd17; start = 1'b1; cmd_ready = 1'b1; row_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         if (row_valid && row_idx == 2'd2) found = 1'b1;
         else begin
            row_ready = 1'b1;
            @(negedge clk);
            row_ready = 1'b0;
         end
      end
      check("reach_row2", 130'(found), 130'(1));
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      check_zero_outputs("mid_reset");
      rst = 1'b0; start = 1'b0;
      run_stream(32'h40, 16'd17, 0);
      check("replay_rows", 130'(row_hs), 130'(4));
      check("replay_row0", 130'(first_row), 130'(128'h42013333_42C8A666_44A72000_3F800000));

      // randomized streams with random readies
      for (int t = 0; t < 25; t++) begin
         b = $urandom_range(0, 300);
         l = $urandom_range(1, 48);
         i = 0;
         while (i < l) begin
            r = $urandom_range(0, 19);
            if (r < 11) begin
               mem[(b + i) % 512] = {1'b0, 19'($urandom), 4'($urandom), 8'h10};
               i++;
            end else if (r < 17) begin
               mem[(b + i) % 512] = {1'b1, 19'($urandom), 4'($urandom), 8'h13};
               for (int p = 1; p <= 16; p++) mem[(b + i + p) % 512] = $urandom;
               i += 17;
            end else if (r < 18) begin
               mem[(b + i) % 512] = 32'h0000_0000;
               i++;
            end else begin
               mem[(b + i) % 512] = {1'b0, 19'($urandom), 4'($urandom), 8'h55};
               i++;
            end
         end
         run_stream(32'(b * 4 + $urandom_range(0, 3)), 16'(l), 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
